// File: rtl/iot_axi_ctrl_regs_pkg.sv
// Shared register map, bit positions, response codes and bus payload types
// for the iot_controller host register file.
package iot_ctrl_regs_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    // Byte offsets of the architected registers
    localparam logic [7:0] REG_CTRL    = 8'h00;
    localparam logic [7:0] REG_STATUS  = 8'h04;
    localparam logic [7:0] REG_NUM_VEC = 8'h08;
    localparam logic [7:0] REG_IRQ_EN  = 8'h0C;
    localparam logic [7:0] REG_CYCLES  = 8'h10;

    // CTRL bits
    localparam int unsigned START_BIT = 0;
    localparam int unsigned CLR_BIT   = 1;

    // STATUS bits
    localparam int unsigned DONE_BIT = 0;
    localparam int unsigned IDLE_BIT = 1;
    localparam int unsigned ERR_BIT  = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        SEL_CTRL,
        SEL_STATUS,
        SEL_NUM_VEC,
        SEL_IRQ_EN,
        SEL_CYCLES,
        SEL_NONE
    } reg_sel_e;

    // Committed write presented by the handshake engine to the register decode
    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } wr_req_t;

    // Map a byte address to a register select; the two low address bits are ignored
    function automatic reg_sel_e reg_decode(input logic [DATA_W-1:0] byte_addr);
        logic [DATA_W-1:0] word_addr;
        word_addr = byte_addr & 32'hFFFF_FFFC;
        case (word_addr)
            32'(REG_CTRL):    return SEL_CTRL;
            32'(REG_STATUS):  return SEL_STATUS;
            32'(REG_NUM_VEC): return SEL_NUM_VEC;
            32'(REG_IRQ_EN):  return SEL_IRQ_EN;
            32'(REG_CYCLES):  return SEL_CYCLES;
            default:          return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/iot_axi_ctrl_regs_if.sv
// AXI4-Lite bus between a host master and the controller register slave.
interface iot_axi_ctrl_regs_if #(
    parameter int unsigned ADDR_W = 6
);
    logic [ADDR_W-1:0] s_axi_awaddr;
    logic              s_axi_awvalid;
    logic              s_axi_awready;
    logic [31:0]       s_axi_wdata;
    logic [3:0]        s_axi_wstrb;
    logic              s_axi_wvalid;
    logic              s_axi_wready;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bvalid;
    logic              s_axi_bready;
    logic [ADDR_W-1:0] s_axi_araddr;
    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic [31:0]       s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rvalid;
    logic              s_axi_rready;

    modport master (
        output s_axi_awaddr, s_axi_awvalid, input s_axi_awready,
        output s_axi_wdata, s_axi_wstrb, s_axi_wvalid, input s_axi_wready,
        input  s_axi_bresp, s_axi_bvalid, output s_axi_bready,
        output s_axi_araddr, s_axi_arvalid, input s_axi_arready,
        input  s_axi_rdata, s_axi_rresp, s_axi_rvalid, output s_axi_rready
    );

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, output s_axi_awready,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid, output s_axi_wready,
        output s_axi_bresp, s_axi_bvalid, input s_axi_bready,
        input  s_axi_araddr, s_axi_arvalid, output s_axi_arready,
        output s_axi_rdata, s_axi_rresp, s_axi_rvalid, input s_axi_rready
    );
endinterface

// File: rtl/iot_axi_ctrl_regs_axil.sv
// AXI4-Lite handshake engine: latches AW and W independently, emits a
// single-cycle write commit once both are held, and samples read data on the
// AR handshake. Register semantics live in the parent.
module iot_axil_slave_if
    import iot_ctrl_regs_pkg::*;
#(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    iot_axi_ctrl_regs_if.slave s_axi,
    output logic              wr_en_c,
    output wr_req_t           wr_req_c,
    input  logic [1:0]        wr_resp_i,
    output logic [DATA_W-1:0] rd_addr_c,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic [1:0]        rd_resp_i
);

    logic              awready_q, awready_d;
    logic              wready_q,  wready_d;
    logic              aw_held_q, aw_held_d;
    logic              w_held_q,  w_held_d;
    logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
    logic [31:0]       w_data_q,  w_data_d;
    logic [3:0]        w_strb_q,  w_strb_d;
    logic              bvalid_q,  bvalid_d;
    logic [1:0]        bresp_q,   bresp_d;
    logic              arready_q, arready_d;
    logic              rvalid_q,  rvalid_d;
    logic [31:0]       rdata_q,   rdata_d;
    logic [1:0]        rresp_q,   rresp_d;

    logic aw_hs_c, w_hs_c, ar_hs_c;
    logic aw_have_c, w_have_c;

    assign aw_hs_c   = s_axi.s_axi_awvalid & awready_q;
    assign w_hs_c    = s_axi.s_axi_wvalid & wready_q;
    assign ar_hs_c   = s_axi.s_axi_arvalid & arready_q;
    assign aw_have_c = aw_held_q | aw_hs_c;
    assign w_have_c  = w_held_q | w_hs_c;

    // Commit in the first cycle both halves are available, bypassing the latches
    assign wr_en_c       = aw_have_c & w_have_c;
    assign wr_req_c.addr = 32'(aw_hs_c ? s_axi.s_axi_awaddr : aw_addr_q);
    assign wr_req_c.data = w_hs_c ? s_axi.s_axi_wdata : w_data_q;
    assign wr_req_c.strb = w_hs_c ? s_axi.s_axi_wstrb : w_strb_q;
    assign rd_addr_c     = 32'(s_axi.s_axi_araddr);

    assign s_axi.s_axi_awready = awready_q;
    assign s_axi.s_axi_wready  = wready_q;
    assign s_axi.s_axi_bvalid  = bvalid_q;
    assign s_axi.s_axi_bresp   = bresp_q;
    assign s_axi.s_axi_arready = arready_q;
    assign s_axi.s_axi_rvalid  = rvalid_q;
    assign s_axi.s_axi_rdata   = rdata_q;
    assign s_axi.s_axi_rresp   = rresp_q;

    // Next-state for both channels; readies stay low while a response is pending
    always_comb begin
        aw_addr_d = aw_addr_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;

        if (aw_hs_c) begin
            aw_addr_d = s_axi.s_axi_awaddr;
        end
        if (w_hs_c) begin
            w_data_d = s_axi.s_axi_wdata;
            w_strb_d = s_axi.s_axi_wstrb;
        end
        aw_held_d = aw_have_c & ~wr_en_c;
        w_held_d  = w_have_c & ~wr_en_c;

        if (wr_en_c) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_resp_i;
        end else if (s_axi.s_axi_bready) begin
            bvalid_d = 1'b0;
        end
        awready_d = ~aw_held_d & ~bvalid_d;
        wready_d  = ~w_held_d & ~bvalid_d;

        if (ar_hs_c) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_data_i;
            rresp_d  = rd_resp_i;
        end else if (s_axi.s_axi_rready) begin
            rvalid_d = 1'b0;
        end
        arready_d = ~rvalid_d;
    end

    // Channel state registers; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            awready_q <= awready_d;
            wready_q  <= wready_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            aw_addr_q <= aw_addr_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

endmodule

// File: rtl/iot_axi_ctrl_regs.sv
// Host-facing register file for iot_controller: START/CLR_IRQ pulses,
// vector count, status, interrupt and busy-cycle counter.
module iot_axi_ctrl_regs
    import iot_ctrl_regs_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 6,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic               clk,
    input  logic               rst,
    iot_axi_ctrl_regs_if.slave s_axi,
    output logic               ctrl_start,
    output logic               ctrl_clear_irq,
    output logic [15:0]        ctrl_num_vectors,
    input  logic               ctrl_done,
    input  logic               ctrl_idle,
    output logic               irq
);

    logic              wr_en_c;
    wr_req_t           wr_req_c;
    logic [1:0]        wr_resp_c;
    logic [DATA_W-1:0] rd_addr_c;
    logic [DATA_W-1:0] rd_data_c;
    logic [1:0]        rd_resp_c;
    reg_sel_e          wr_sel_c;
    reg_sel_e          rd_sel_c;

    logic [15:0]          num_vec_q, num_vec_d;
    logic                 irq_en_q,  irq_en_d;
    logic                 err_q,     err_d;
    logic [CNT_WIDTH-1:0] cycles_q,  cycles_d;
    logic                 start_q,   start_d;
    logic                 clr_q,     clr_d;
    logic                 irq_q,     irq_d;

    logic unused_wr_bits;
    assign unused_wr_bits = ^{wr_req_c.data[31:16], wr_req_c.strb[3:2]};

    iot_axil_slave_if #(
        .ADDR_W (AXI_ADDR_WIDTH)
    ) u_axil (
        .clk       (clk),
        .rst       (rst),
        .s_axi     (s_axi),
        .wr_en_c   (wr_en_c),
        .wr_req_c  (wr_req_c),
        .wr_resp_i (wr_resp_c),
        .rd_addr_c (rd_addr_c),
        .rd_data_i (rd_data_c),
        .rd_resp_i (rd_resp_c)
    );

    assign wr_sel_c  = reg_decode(wr_req_c.addr);
    assign rd_sel_c  = reg_decode(rd_addr_c);
    assign wr_resp_c = (wr_sel_c == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;

    assign ctrl_start       = start_q;
    assign ctrl_clear_irq   = clr_q;
    assign ctrl_num_vectors = num_vec_q;
    assign irq              = irq_q;

    // Read mux over current register state (pre-write values on a same-cycle write)
    always_comb begin
        rd_data_c = '0;
        rd_resp_c = RESP_OKAY;
        case (rd_sel_c)
            SEL_STATUS: begin
                rd_data_c[DONE_BIT] = ctrl_done;
                rd_data_c[IDLE_BIT] = ctrl_idle;
                rd_data_c[ERR_BIT]  = err_q;
            end
            SEL_NUM_VEC: rd_data_c = 32'(num_vec_q);
            SEL_IRQ_EN:  rd_data_c = 32'(irq_en_q);
            SEL_CYCLES:  rd_data_c = 32'(cycles_q);
            SEL_NONE:    rd_resp_c = RESP_SLVERR;
            default:     rd_data_c = '0;
        endcase
    end

    // Register updates, command pulses and busy-cycle counting
    always_comb begin
        num_vec_d = num_vec_q;
        irq_en_d  = irq_en_q;
        err_d     = err_q;
        cycles_d  = cycles_q;
        start_d   = 1'b0;
        clr_d     = 1'b0;
        irq_d     = ctrl_done & irq_en_q;

        if (!ctrl_idle && !ctrl_done && (cycles_q != '1)) begin
            cycles_d = cycles_q + CNT_WIDTH'(1);
        end

        if (wr_en_c) begin
            case (wr_sel_c)
                SEL_CTRL: begin
                    if (wr_req_c.strb[0]) begin
                        if (wr_req_c.data[CLR_BIT]) begin
                            clr_d = 1'b1;
                            err_d = 1'b0;
                        end
                        // A refused start sets err even when CLR_IRQ is written alongside
                        if (wr_req_c.data[START_BIT]) begin
                            if (ctrl_idle && (num_vec_q != '0)) begin
                                start_d  = 1'b1;
                                cycles_d = '0;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                    end
                end
                SEL_NUM_VEC: begin
                    if (ctrl_idle) begin
                        if (wr_req_c.strb[0]) num_vec_d[7:0]  = wr_req_c.data[7:0];
                        if (wr_req_c.strb[1]) num_vec_d[15:8] = wr_req_c.data[15:8];
                    end else begin
                        err_d = 1'b1;
                    end
                end
                SEL_IRQ_EN: begin
                    if (wr_req_c.strb[0]) irq_en_d = wr_req_c.data[0];
                end
                default: begin
                    err_d = err_q;
                end
            endcase
        end
    end

    // Register state; reset drops every output and suppresses pending pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            num_vec_q <= '0;
            irq_en_q  <= 1'b0;
            err_q     <= 1'b0;
            cycles_q  <= '0;
            start_q   <= 1'b0;
            clr_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            num_vec_q <= num_vec_d;
            irq_en_q  <= irq_en_d;
            err_q     <= err_d;
            cycles_q  <= cycles_d;
            start_q   <= start_d;
            clr_q     <= clr_d;
            irq_q     <= irq_d;
        end
    end

endmodule

// File: doc/iot_axi_ctrl_regs.md
Name: iot_axi_ctrl_regs

Overview:
AXI4-Lite slave register file that sits in front of iot_controller and drives its command interface. It provides the start/clear_irq pulses and num_vectors, and exposes done/idle, an interrupt and a busy-cycle counter to the host CPU. It is the host-facing end of the controller's start/done handshake.

Parameters:
AXI_ADDR_WIDTH, 6, byte address width; registers decoded on addr[4:2], addr[1:0] ignored
CNT_WIDTH, 32, width of the busy-cycle counter (at most 32)

Ports:
clk  in  1  single clock
rst  in  1  synchronous reset, active-high
s_axi_awaddr  in  AXI_ADDR_WIDTH  write address
s_axi_awvalid / s_axi_awready  in / out  1  AW handshake
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte strobes
s_axi_wvalid / s_axi_wready  in / out  1  W handshake
s_axi_bresp  out  2  00 OKAY, 10 SLVERR
s_axi_bvalid / s_axi_bready  out / in  1  B handshake
s_axi_araddr  in  AXI_ADDR_WIDTH  read address
s_axi_arvalid / s_axi_arready  in / out  1  AR handshake
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  00 OKAY, 10 SLVERR
s_axi_rvalid / s_axi_rready  out / in  1  R handshake
ctrl_start  out  1  one-cycle start pulse to controller
ctrl_clear_irq  out  1  one-cycle clear pulse to controller
ctrl_num_vectors  out  16  vector count, stable while busy
ctrl_done  in  1  controller done (sticky until clear_irq)
ctrl_idle  in  1  controller idle
irq  out  1  level interrupt, registered

Behaviour:
- Register map:
  - 0x00 CTRL (WO; reads 0): bit0 START, bit1 CLR_IRQ. Acts only if wstrb[0].
  - 0x04 STATUS (RO): bit0 done, bit1 idle, bit2 err (sticky).
  - 0x08 NUM_VEC (RW): [15:0], byte-strobed; reset 0.
  - 0x0C IRQ_EN (RW): bit0, byte-strobed; reset 0.
  - 0x10 CYCLES (RO): busy-cycle counter, zero-extended to 32.
  - Any other address: write ignored, BRESP=SLVERR; read returns RDATA=0, RRESP=SLVERR.
- Reset (rst=1): every output is 0, including all ready signals. From the first cycle after reset, awready, wready and arready are 1.
- Write channel:
  - AW and W are accepted independently. Each is latched and its ready drops after its own handshake.
  - Commit happens in the first cycle both are held, including the same cycle if both arrive together.
  - bvalid rises the cycle after commit and holds until bready.
  - awready and wready stay 0 while bvalid=1. They return to 1 the cycle after the B handshake.
  - No second write is accepted while B is outstanding.
- Read channel:
  - On AR handshake at cycle T, register data is sampled at T. rvalid=1 and rdata are driven at T+1.
  - arready=0 until the R handshake. rdata and rresp are held stable while rvalid=1 and rready=0.
- Simultaneous read and write of the same register in one cycle: the read returns the pre-write value.
- START (commit at T):
  - If ctrl_idle=1 and NUM_VEC!=0: ctrl_start=1 for exactly cycle T+1, and CYCLES clears to 0 at T+1.
  - Otherwise: no pulse, and err is set at T+1.
  - BRESP is OKAY in both cases.
- CLR_IRQ: ctrl_clear_irq=1 for exactly cycle T+1; err is cleared at T+1.
- START and CLR_IRQ written together: both pulses fire in the same cycle.
- ctrl_num_vectors = NUM_VEC register. Writes to NUM_VEC while ctrl_idle=0 are ignored (BRESP OKAY) and set err.
- CYCLES:
  - Increments by 1 each cycle ctrl_idle=0 and ctrl_done=0.
  - Saturates at all-ones.
  - Holds when idle or done.
- irq <= ctrl_done & IRQ_EN[0], registered (1-cycle latency).
- Reset mid-transaction: all handshakes are abandoned, registers return to reset values, and no pulse is emitted.

Decomposition:
- Package iot_ctrl_regs_pkg holds:
  - register offsets: REG_CTRL, REG_STATUS, REG_NUM_VEC, REG_IRQ_EN, REG_CYCLES
  - bit indices: START_BIT, CLR_BIT, DONE_BIT, IDLE_BIT, ERR_BIT
  - response codes RESP_OKAY and RESP_SLVERR
- One natural sub-module, iot_axil_slave_if: AXI-Lite handshake engine with write-commit and read-strobe outputs. The register decode stays in the top.

Test Plan:
- Write NUM_VEC=0x0008 with AW/W in the same cycle, then read it back -> bvalid 1 cycle after commit, BRESP=00; RDATA=0x00000008, RRESP=00.
- With ctrl_idle=1, write CTRL=0x1 -> ctrl_start high exactly 1 cycle; bench controller goes busy for 20 cycles, then done=1 -> CYCLES reads 20; STATUS reads 0x1.
- Write IRQ_EN=1, assert ctrl_done -> irq rises 1 cycle later; write CTRL=0x2 -> ctrl_clear_irq 1-cycle pulse; done drops -> irq drops 1 cycle later.
- Write CTRL=0x1 while ctrl_idle=0, and NUM_VEC=5 while busy -> no start pulse; NUM_VEC unchanged; STATUS bit2=1; a later CTRL=0x2 clears it.
- AW 3 cycles before W, bready held low 4 cycles, rready held low during a read -> exactly one commit; bvalid and rdata stable until accepted; no new AW/AR accepted meanwhile.
- Read 0x1C and write 0x18 -> RRESP=10 with RDATA=0; BRESP=10 with no register change. Assert rst mid-write -> all outputs 0; no ctrl_start.
